// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-interface types.
//   word_t     : 32-bit machine word
//   ramstate_t : RAM model handshake state (FREE/BUSY/ACCESS/ERROR)
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

endpackage

// File: rtl/access_timer.sv
// Per-access wait counter for the memory responder.
// Ports:
//   i_clk     : clock, rising edge
//   i_rst     : asynchronous active-high reset
//   i_clr     : synchronous clear (highest priority after reset)
//   i_inc     : increment by one
//   o_expired : counter equals TIMEOUT-1
module access_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the datapath cache interface. Serves instruction
// fetches and data accesses from a single-ported RAM, data first.
// Ports:
//   CLK, RST                    : clock, async active-high reset
//   imemREN/imemaddr            : fetch request (held until ihit)
//   imemload/ihit               : registered fetch data, one-cycle done pulse
//   dmemREN/dmemWEN/dmemaddr/
//   dmemstore                   : data request (held until dhit)
//   dmemload/dhit               : registered read data, one-cycle done pulse
//   halt                        : blocks new fetches only
//   ramREN/ramWEN/ramaddr/
//   ramstore/ramload/ramstate   : RAM side
//   err                         : sticky error (RAM error or timeout)
module mem_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  input  logic        halt,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, DREQ, IREQ, DHIT, IHIT, ERR} state_t;

  state_t    r_state, w_state_next;
  word_t     r_addr, r_store, r_imemload, r_dmemload;
  logic      r_wr;
  ramstate_t w_rs;
  logic      w_expired, w_tmr_inc, w_latch_d, w_latch_i, w_cap;

  assign w_rs = ramstate_t'(ramstate);

  // Counter is held clear in IDLE, so every entry to DREQ/IREQ starts at zero.
  access_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_clr     (r_state == IDLE),
    .i_inc     (w_tmr_inc),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch_d    = 1'b0;
    w_latch_i    = 1'b0;
    w_cap        = 1'b0;
    w_tmr_inc    = 1'b0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ihit         = 1'b0;
    dhit         = 1'b0;
    err          = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (dmemREN || dmemWEN) begin
          w_latch_d    = 1'b1;
          w_state_next = DREQ;
        end else if (imemREN && !halt) begin
          w_latch_i    = 1'b1;
          w_state_next = IREQ;
        end
      end
      DREQ, IREQ: begin
        // r_wr is always 0 for a fetch, so one expression covers both states.
        ramREN = ~r_wr;
        ramWEN = r_wr;
        unique case (w_rs)
          ACCESS: begin
            w_cap        = 1'b1;
            w_state_next = (r_state == DREQ) ? DHIT : IHIT;
          end
          ERROR: w_state_next = ERR;
          default: begin
            if (w_expired) begin
              w_state_next = ERR;
            end else begin
              w_tmr_inc = 1'b1;
            end
          end
        endcase
      end
      DHIT: begin
        dhit         = 1'b1;
        w_state_next = IDLE;
      end
      IHIT: begin
        ihit         = 1'b1;
        w_state_next = IDLE;
      end
      ERR: err = 1'b1;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr     <= '0;
      r_store    <= '0;
      r_wr       <= 1'b0;
      r_imemload <= '0;
      r_dmemload <= '0;
    end else begin
      if (w_latch_d) begin
        r_addr  <= dmemaddr;
        r_store <= dmemstore;
        r_wr    <= dmemWEN;
      end else if (w_latch_i) begin
        r_addr <= imemaddr;
        r_wr   <= 1'b0;
      end
      if (w_cap) begin
        if (r_state == IREQ) begin
          r_imemload <= ramload;
        end else if (!r_wr) begin
          r_dmemload <= ramload;
        end
      end
    end
  end

  assign ramaddr  = r_addr;
  assign ramstore = r_store;
  assign imemload = r_imemload;
  assign dmemload = r_dmemload;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for `datapath_cache_if`: serves the pipeline's instruction-fetch and data requests from a single-ported RAM.
- Generates the `ihit`/`dhit` pulses and load data that the datapath's PC and pipeline latches advance on.
- Sits between the datapath and the RAM model.
- Data requests take priority over fetches; a stuck RAM is detected by a timeout counter.

Parameters:
- TIMEOUT, 64, maximum consecutive BUSY cycles tolerated per access before entering the error state (must be >= 2).

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- imemREN  in  1  instruction read request, held until ihit
- imemaddr  in  32  instruction address
- imemload  out  32  fetched instruction, registered
- ihit  out  1  one-cycle instruction-done pulse
- dmemREN  in  1  data read request, held until dhit
- dmemWEN  in  1  data write request, held until dhit
- dmemaddr  in  32  data address
- dmemstore  in  32  write data
- dmemload  out  32  read data, registered
- dhit  out  1  one-cycle data-done pulse
- halt  in  1  pipeline halted; blocks new instruction fetches
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid when ramstate==ACCESS
- ramstate  in  2  FREE/BUSY/ACCESS/ERROR
- err  out  1  sticky error flag

Behaviour:
- Reset (RST=1, asynchronous) values:
  - state=IDLE
  - ihit=dhit=0, imemload=dmemload=0
  - ramREN=ramWEN=0, ramaddr=ramstore=0
  - err=0, timeout counter=0
- Reset asserted mid-access aborts the access; no hit is produced.
- States: IDLE, DREQ, IREQ, DHIT, IHIT, ERR.
- IDLE:
  - If dmemREN|dmemWEN: latch dmemaddr, dmemstore and the op (write if dmemWEN=1, even when dmemREN=1 too), go to DREQ.
  - Else if imemREN & ~halt: latch imemaddr, go to IREQ.
  - Else stay.
  - Data wins when both request in the same cycle.
- DREQ / IREQ:
  - ramaddr and ramstore come from the latched registers. ramREN = read op; ramWEN = write op (DREQ only); IREQ drives ramREN=1, ramWEN=0.
  - ramstate==ACCESS: capture ramload into dmemload (DREQ read) or imemload (IREQ); go to DHIT/IHIT. A data write leaves dmemload unchanged.
  - ramstate==BUSY or FREE: increment the counter; when the counter reaches TIMEOUT-1, go to ERR.
  - ramstate==ERROR: go to ERR immediately.
  - Counter clears on every entry to DREQ/IREQ.
- DHIT / IHIT:
  - Drive dhit=1 (resp. ihit=1) for exactly one cycle, with the load data already stable; RAM strobes are 0; go to IDLE.
  - The held request is not re-sampled until IDLE.
- Latency: request visible at edge k → hit high in the cycle after edge k+2, assuming zero-wait RAM (ACCESS on the first request cycle). Each BUSY cycle adds one.
- Back-to-back requests: minimum 3 cycles per request (IDLE, REQ, HIT).
- ERR: err=1, hits=0, strobes=0; exits only on RST.
- halt=1 only suppresses new fetches. An in-flight IREQ completes, and data requests are still served.
- imemload and dmemload hold their values until the next hit of the same type.
- ihit and dhit are never high in the same cycle.

Decomposition:
- `ramstate_t` (FREE=2'b00, BUSY=2'b01, ACCESS=2'b10, ERROR=2'b11) and `word_t` belong in `cpu_types_pkg`.
- The FSM state enum is local to the module.
- One natural sub-module, `access_timer`: clear/increment counter with a TIMEOUT-1 compare output.

Test Plan:
- Instruction fetch: imemREN=1, imemaddr=0x00000040, RAM returns ACCESS with ramload=0x8C220004 on first request cycle → ihit pulses 2 cycles after request, imemload=0x8C220004, ramaddr=0x40 during IREQ.
- Priority: dmemREN=1 (addr 0x100, ramload 0xDEADBEEF) and imemREN=1 in the same cycle → dhit first with dmemload=0xDEADBEEF; ihit 3 cycles later; never coincident.
- Write with wait states: dmemWEN=1, addr 0x200, store 0x12345678, RAM BUSY 3 cycles then ACCESS → ramWEN=1, ramstore=0x12345678 held 4 cycles; dhit 1 cycle; dmemload unchanged.
- Timeout: RAM held BUSY, TIMEOUT=8 → ERR after 8 request cycles, err=1 sticky; further requests get no hits until RST.
- Halt: halt=1 with imemREN=1 and no data request → no RAM strobes, no ihit; a data read issued while halted still completes with dhit.
- Reset mid-access: RST asserted during DREQ with RAM BUSY → all outputs 0 immediately; after release, a new fetch completes normally.
